sfx_arbiter: RTL and testbench
==============================

Name: sfx_arbiter

Overview:
- Owns the single SPEAKER output and shares it between background music and four one-shot sound-effect requesters: jump, egg collected, hit, game over.
- Each effect is a two-note square-wave sequence. Priority arbitration lets higher-priority effects preempt lower ones.
- Background music passes through only when no effect is active.
- Sits between the game logic (event pulses, game state) and the speaker pin, downstream of the music players.

Parameters:
- TICK_DIV, 250: prescaler; tone and duration counters advance once every TICK_DIV clk cycles (100 kHz at 25 MHz). Tests use 1.
- HP_W, 8: half-period counter width.
- DUR_W, 16: duration counter width.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- en, input, 1: sound enable; low forces silence and aborts any effect.
- music_in, input, 1: background music square wave (already gated by game state).
- req, input, 4: one-cycle event pulses. Bit 0 jump, 1 egg, 2 hit, 3 gameover. Higher index = higher priority.
- speaker, output, 1: registered speaker drive.
- sfx_active, output, 1: high while an effect plays.
- sfx_id, output, 2: id of the current or last effect.
- done, output, 1: one-cycle pulse when an effect completes naturally.

Behaviour:
- Reset values: speaker=0, sfx_active=0, sfx_id=0, done=0, state=IDLE, all counters and the tone level at 0.
- Tick: prescaler counts 0..TICK_DIV-1 and asserts tick on TICK_DIV-1. It is cleared on every effect start.
- Arbitration, each clk:
  - winner = highest set bit of req.
  - Accept if any of: state==IDLE; winner > cur_id (preempt); winner == cur_id (restart from NOTE1).
  - winner < cur_id while active: dropped, not queued.
  - No requests are accepted while en=0.
- Accept takes effect on the next clk edge: state=NOTE1, cur_id=winner, tone_cnt=0, dur_cnt=0, tone=0, done not pulsed.
- States:
  - IDLE: no effect active.
  - NOTE1: on each tick, tone_cnt increments. At tone_cnt==HP1[id]-1, tone toggles and tone_cnt=0. dur_cnt increments on each tick. At dur_cnt==DUR[id]-1 on a tick, go to NOTE2 with tone_cnt=0, dur_cnt=0, tone=0.
  - NOTE2: same counting using HP2[id]. At dur_cnt==DUR[id]-1 on a tick, go to IDLE and pulse done for one cycle.
- Square wave: period 2*HP ticks, starting low; first rise HP ticks after note start.
- Output mux, registered one cycle:
  - en=0: speaker=0.
  - Effect active: speaker=tone.
  - Otherwise: speaker=music_in.
- sfx_active = (state != IDLE). sfx_id holds cur_id after completion.
- en falling mid-effect: next edge goes to IDLE; no done pulse.
- Reset asserted mid-effect: immediate clear; done not pulsed.
- Simultaneous accept and natural completion in the same cycle: the accept wins; done is not pulsed.

Decomposition:
- Shared constants file sfx_defs: effect ids SFX_JUMP=0, SFX_EGG=1, SFX_HIT=2, SFX_GAMEOVER=3. Tables, in ticks:
  - jump: HP1=60, HP2=40, DUR=2000.
  - egg: HP1=38, HP2=25, DUR=4000.
  - hit: HP1=100, HP2=150, DUR=8000.
  - gameover: HP1=120, HP2=200, DUR=30000.
- Sub-module sfx_tone_gen: the tone divider plus duration counter. Inputs: tick, start, half_period, duration. Outputs: tone, note_end.
- sfx_arbiter keeps the prescaler, arbitration, the IDLE/NOTE1/NOTE2 FSM and the output mux.

Test Plan (TICK_DIV=1, en=1):
- Music pass-through: music_in toggling every 10 cycles with no req -> speaker follows music_in delayed 1 cycle; sfx_active=0.
- Egg effect: req=0010 for one cycle.
  - Edge after the pulse: sfx_active=1, sfx_id=1.
  - Speaker high/low runs of 38 cycles for 4000 cycles, then runs of 25 for 4000.
  - done pulses once 8000 cycles after start; speaker then returns to music_in.
- Preempt: jump req, then hit req 500 cycles later -> sfx_id=2 on the next edge; speaker runs of 100 cycles; no done pulse for the jump.
- Drop and restart:
  - During hit, req=0001 -> ignored; hit timing unchanged.
  - req=0100 mid-NOTE2 -> restarts NOTE1 with runs of 100.
- Simultaneous requests: req=1011 -> sfx_id=3; runs of 120 for 30000 cycles, then 200 for 30000; done at 60000.
- Abort paths:
  - en dropped mid-effect -> speaker=0 next cycle, sfx_active=0, no done.
  - Async reset mid-effect -> all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/sfx_arbiter_pkg.sv
// sfx_arbiter_pkg: effect ids, FSM states and per-effect note tables (in ticks)
package sfx_arbiter_pkg;
  typedef enum logic [1:0] {SFX_JUMP, SFX_EGG, SFX_HIT, SFX_GAMEOVER} sfx_id_t;
  typedef enum logic [1:0] {IDLE, NOTE1, NOTE2} state_t;
  function automatic int hp1(logic [1:0] id);
    return id == SFX_JUMP ? 60 : id == SFX_EGG ? 38 : id == SFX_HIT ? 100 : 120;
  endfunction
  function automatic int hp2(logic [1:0] id);
    return id == SFX_JUMP ? 40 : id == SFX_EGG ? 25 : id == SFX_HIT ? 150 : 200;
  endfunction
  function automatic int dur(logic [1:0] id);
    return id == SFX_JUMP ? 2000 : id == SFX_EGG ? 4000 : id == SFX_HIT ? 8000 : 30000;
  endfunction
endpackage

// File: rtl/sfx_arbiter_tone_gen.sv
// sfx_tone_gen: square-wave divider plus note duration counter, advanced on tick
module sfx_tone_gen #(
  parameter int HP_W = 8,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [HP_W-1:0]  half_period,
  input  logic [DUR_W-1:0] duration,
  output logic             tone,
  output logic             note_end
);
  logic [HP_W-1:0] tone_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic tone_wrap;
  assign tone_wrap = tone_cnt == half_period - HP_W'(1);
  assign note_end = tick && !start && dur_cnt == duration - DUR_W'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_cnt <= '0;
      dur_cnt <= '0;
      tone <= 1'b0;
    end else if (start || note_end) begin
      tone_cnt <= '0;
      dur_cnt <= '0;
      tone <= 1'b0;
    end else if (tick) begin
      tone_cnt <= tone_wrap ? '0 : tone_cnt + HP_W'(1);
      tone <= tone ^ tone_wrap;
      dur_cnt <= dur_cnt + DUR_W'(1);
    end
  end
endmodule

// File: rtl/sfx_arbiter.sv
// sfx_arbiter: prioritised two-note sound effects preempting background music on the speaker
module sfx_arbiter
  import sfx_arbiter_pkg::*;
#(
  parameter int TICK_DIV = 250,
  parameter int HP_W = 8,
  parameter int DUR_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       music_in,
  input  logic [3:0] req,
  output logic       speaker,
  output logic       sfx_active,
  output logic [1:0] sfx_id,
  output logic       done
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  state_t state, state_nxt;
  logic [1:0] cur_id, winner;
  logic tick, accept, tone, note_end, done_nxt;
  assign winner = req[3] ? 2'd3 : req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0;
  assign tick = pre == PW'(TICK_DIV - 1);
  assign accept = en && |req && (state == IDLE || winner >= cur_id);
  assign sfx_active = state != IDLE;
  assign sfx_id = cur_id;
  sfx_tone_gen #(.HP_W(HP_W), .DUR_W(DUR_W)) u_tone (
    .clk(clk),
    .reset(reset),
    .tick(tick && sfx_active && en),
    .start(accept),
    .half_period(HP_W'(state == NOTE2 ? hp2(cur_id) : hp1(cur_id))),
    .duration(DUR_W'(dur(cur_id))),
    .tone(tone),
    .note_end(note_end)
  );
  // an accept landing on the final tick overrides completion, so no done pulse
  always_comb begin
    state_nxt = state;
    done_nxt = 1'b0;
    if (!en) state_nxt = IDLE;
    else if (accept) state_nxt = NOTE1;
    else if (note_end) begin
      state_nxt = state == NOTE1 ? NOTE2 : IDLE;
      done_nxt = state == NOTE2;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur_id <= 2'd0;
      pre <= '0;
      speaker <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= done_nxt;
      pre <= (accept || tick) ? '0 : pre + PW'(1);
      if (accept) cur_id <= winner;
      speaker <= en && (sfx_active ? tone : music_in);
    end
  end
endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: random and directed stimulus against an elapsed-time model of the effects
module tb_sfx_arbiter;
  logic clk = 1'b0, reset = 1'b1, en = 1'b1, music_in = 1'b0, speaker, sfx_active, done;
  logic [3:0] req = 4'd0;
  logic [1:0] sfx_id;
  int total = 0, bad = 0;
  int hp_a[4] = '{60, 38, 100, 120};
  int hp_b[4] = '{40, 25, 150, 200};
  int len[4] = '{2000, 4000, 8000, 30000};
  bit m_act = 0, m_spk = 0, m_done = 0;
  logic [1:0] m_id = 2'd0;
  int m_e = 0;
  sfx_arbiter #(.TICK_DIV(1), .HP_W(8), .DUR_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .music_in(music_in), .req(req),
    .speaker(speaker), .sfx_active(sfx_active), .sfx_id(sfx_id), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [4:0] got, logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask
  function automatic bit m_tone();
    return m_e < len[m_id] ? bit'((m_e / hp_a[m_id]) % 2) : bit'(((m_e - len[m_id]) / hp_b[m_id]) % 2);
  endfunction
  task automatic cycle(string tag);
    logic [1:0] w;
    bit acc, nspk;
    w = req[3] ? 2'd3 : req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0;
    nspk = !en ? 1'b0 : m_act ? m_tone() : music_in;
    acc = en && req != 0 && (!m_act || w >= m_id);
    m_done = 0;
    if (acc) begin
      m_act = 1; m_id = w; m_e = 0;
    end else if (!en) m_act = 0;
    else if (m_act) begin
      m_e++;
      if (m_e == 2 * len[m_id]) begin m_act = 0; m_done = 1; end
    end
    m_spk = nspk;
    @(posedge clk); #1;
    check(tag, {speaker, sfx_active, sfx_id, done}, {m_spk, m_act, m_id, m_done});
  endtask
  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask
  task automatic pulse(logic [3:0] r, string tag);
    req = r;
    cycle(tag);
    req = 4'd0;
  endtask
  initial begin
    #1 check("reset", {speaker, sfx_active, sfx_id, done}, 5'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) music_in = ~music_in;
      cycle("music");
    end
    pulse(4'b0010, "egg_start");
    check("egg_id", {3'd0, sfx_active, sfx_id}, 5'b00_1_01);
    run("egg", 8010);
    pulse(4'b0001, "jump");
    run("jump", 499);
    pulse(4'b0100, "preempt");
    check("hit_id", {3'd0, sfx_active, sfx_id}, 5'b00_1_10);
    run("hit", 200);
    pulse(4'b0001, "drop");
    run("hit", 8100);
    pulse(4'b0100, "restart");
    run("restart", 300);
    en = 1'b0;
    run("en_off", 3);
    en = 1'b1;
    run("en_on", 50);
    pulse(4'b1011, "multi");
    check("go_id", {3'd0, sfx_active, sfx_id}, 5'b00_1_11);
    run("gameover", 60010);
    for (int i = 0; i < 8000; i++) begin
      req = $urandom_range(299) == 0 ? 4'($urandom_range(15)) : 4'd0;
      en = $urandom_range(3999) != 0;
      if ($urandom_range(7) == 0) music_in = ~music_in;
      cycle("rand");
    end
    req = 4'd0; en = 1'b1;
    pulse(4'b0010, "egg2");
    run("egg2", 100);
    #2 reset = 1'b1;
    #1 check("areset", {speaker, sfx_active, sfx_id, done}, 5'd0);
    m_act = 0; m_id = 2'd0; m_e = 0; m_done = 0; m_spk = 0;
    @(posedge clk); #1 reset = 1'b0;
    check("post_rst", {speaker, sfx_active, sfx_id, done}, 5'd0);
    run("idle", 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
